// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC scan controller and its arbiter.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    START,
    WAIT,
    DONE
  } state_t;

  localparam int VOL_W_DEF = 12;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_rr_arb.sv
// Combinational round-robin pick: first set req bit after rr_ptr, wrapping modulo NUM_CH.
module adc_rr_arb
  import adc_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [CH_W-1:0]   grant,
  output logic              any_req
);

  logic [CH_W-1:0] idx;

  // Scan farthest-to-nearest so the closest requester after rr_ptr is written last.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin scan scheduler for the shared sampler/averaging converter.
// Grant -> mux select, settle, one start pulse, wait con_end under watchdog, ack.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SETTLE_CYC  = 1000,
  parameter int TIMEOUT_CYC = 216300000,
  parameter int CNT_W       = 28,
  parameter int VOL_W       = VOL_W_DEF,
  localparam int CH_W       = ch_w(NUM_CH)
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] ack,
  output logic [CH_W-1:0]   ch_sel,
  output logic              sam_start,
  input  logic              con_end,
  input  logic [VOL_W-1:0]  vol,
  output logic [VOL_W-1:0]  result,
  output logic [CH_W-1:0]   result_ch,
  output logic              result_vld,
  output logic              timeout_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state, state_nxt;
  logic [CH_W-1:0]  rr_ptr, rr_nxt;
  logic [CH_W-1:0]  grant_ch, grant_nxt, ch_sel_nxt;
  logic [CH_W-1:0]  pick;
  logic             any_req;
  logic [CNT_W-1:0] settle_cnt, settle_nxt;
  logic [CNT_W-1:0] wd_cnt, wd_nxt;
  logic             start_nxt, done_nxt, vld_nxt, tmo_nxt, latch_res;

  adc_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_ptr;
    grant_nxt  = grant_ch;
    ch_sel_nxt = ch_sel;
    settle_nxt = settle_cnt;
    wd_nxt     = wd_cnt;
    start_nxt  = 1'b0;
    done_nxt   = 1'b0;
    vld_nxt    = 1'b0;
    tmo_nxt    = 1'b0;
    latch_res  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt  = SETTLE;
          grant_nxt  = pick;
          ch_sel_nxt = pick;
          settle_nxt = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = START;
          start_nxt = 1'b1;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      START: begin
        wd_nxt    = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A conversion landing on the last watchdog cycle still counts as success.
        if (con_end) begin
          latch_res = 1'b1;
          vld_nxt   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else if (wd_cnt == WD_LAST) begin
          tmo_nxt   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
        end
      end
      DONE: begin
        rr_nxt    = grant_ch;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pulse outputs are registered on the transition so they coincide with the target state.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state       <= IDLE;
      rr_ptr      <= CH_W'(NUM_CH - 1);
      grant_ch    <= '0;
      ch_sel      <= '0;
      settle_cnt  <= '0;
      wd_cnt      <= '0;
      sam_start   <= 1'b0;
      ack         <= '0;
      result      <= '0;
      result_ch   <= '0;
      result_vld  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      grant_ch    <= grant_nxt;
      ch_sel      <= ch_sel_nxt;
      settle_cnt  <= settle_nxt;
      wd_cnt      <= wd_nxt;
      sam_start   <= start_nxt;
      ack         <= done_nxt ? (NUM_CH'(1) << grant_ch) : '0;
      result_vld  <= vld_nxt;
      timeout_err <= tmo_nxt;
      if (latch_res) begin
        result    <= vol;
        result_ch <= grant_ch;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
